// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with a prescaled step, wrap carry pulse and a
// multiplexed display scan producing one registered digit plus its anode select.
module bcd_scan_counter #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        up_dn,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] count_bcd,
    output logic        carry,
    output logic [3:0]  nibble_out,
    output logic [3:0]  digit_an
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

    logic [PW-1:0] presc;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [1:0]    an_idx;

    logic [15:0] cnt_up, cnt_dn, load_clean;
    logic        wrap_up, wrap_dn;

    // Decimal ripple: a digit only moves while every lower digit wrapped.
    always_comb begin
        logic       ripple_up, ripple_dn;
        logic [3:0] d;
        cnt_up     = count_bcd;
        cnt_dn     = count_bcd;
        load_clean = '0;
        ripple_up  = 1'b1;
        ripple_dn  = 1'b1;
        d          = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            d = count_bcd[i*4 +: 4];
            if (ripple_up) begin
                if (d == 4'd9) begin
                    cnt_up[i*4 +: 4] = 4'd0;
                end else begin
                    cnt_up[i*4 +: 4] = d + 4'd1;
                    ripple_up        = 1'b0;
                end
            end
            if (ripple_dn) begin
                if (d == 4'd0) begin
                    cnt_dn[i*4 +: 4] = 4'd9;
                end else begin
                    cnt_dn[i*4 +: 4] = d - 4'd1;
                    ripple_dn        = 1'b0;
                end
            end
            load_clean[i*4 +: 4] = (load_val[i*4 +: 4] > 4'd9) ? 4'd0 : load_val[i*4 +: 4];
        end
        wrap_up = ripple_up;
        wrap_dn = ripple_dn;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_bcd <= '0;
            presc     <= '0;
            carry     <= 1'b0;
        end else begin
            carry <= 1'b0;
            if (clear) begin
                count_bcd <= '0;
                presc     <= '0;
            end else if (load) begin
                count_bcd <= load_clean;
                presc     <= '0;
            end else if (en) begin
                if (presc == PRESC_LAST) begin
                    presc <= '0;
                    if (up_dn) begin
                        count_bcd <= cnt_up;
                        carry     <= wrap_up;
                    end else begin
                        count_bcd <= cnt_dn;
                        carry     <= wrap_dn;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    // Anode index trails the nibble by one cycle to match the encoder register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt   <= '0;
            idx        <= '0;
            an_idx     <= '0;
            nibble_out <= '0;
            digit_an   <= '1;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            nibble_out <= count_bcd[{idx, 2'b00} +: 4];
            an_idx     <= idx;
            digit_an   <= ~(4'b0001 << an_idx);
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Randomized and directed bench for bcd_scan_counter against an integer-valued
// model of the count, prescaler and display scan.
module tb_bcd_scan_counter;

    localparam int TD = 4;
    localparam int SD = 2;

    logic        clk = 1'b0;
    logic        rst_n, en, up_dn, clear, load;
    logic [15:0] load_val;
    logic [15:0] count_bcd;
    logic        carry;
    logic [3:0]  nibble_out, digit_an;

    bcd_scan_counter #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .count_bcd(count_bcd), .carry(carry),
        .nibble_out(nibble_out), .digit_an(digit_an)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: count kept as a plain integer 0..9999.
    int         m_cnt, m_pre, m_t;
    bit         m_car, m_valid = 0;
    logic [3:0] m_nib, m_an;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int from_load(input logic [15:0] lv);
        int r = 0;
        int w = 1;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] d = lv[i*4 +: 4];
            if (d <= 4'd9) r += int'(d) * w;
            w *= 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] digit_of(input int v, input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p *= 10;
        return 4'(v / p % 10);
    endfunction

    task automatic model_edge(input bit r, input bit e, input bit u, input bit c,
                              input bit l, input logic [15:0] lv);
        int prev, i_now, i_prev;
        if (!r) begin
            m_cnt = 0; m_pre = 0; m_car = 0; m_t = 0;
            m_nib = 4'h0; m_an = 4'hF; m_valid = 1;
        end else begin
            prev  = m_cnt;
            m_car = 0;
            if (c) begin
                m_cnt = 0; m_pre = 0;
            end else if (l) begin
                m_cnt = from_load(lv); m_pre = 0;
            end else if (e) begin
                if (m_pre == TD - 1) begin
                    m_pre = 0;
                    if (u) begin
                        if (m_cnt == 9999) begin m_cnt = 0; m_car = 1; end
                        else m_cnt = m_cnt + 1;
                    end else begin
                        if (m_cnt == 0) begin m_cnt = 9999; m_car = 1; end
                        else m_cnt = m_cnt - 1;
                    end
                end else begin
                    m_pre++;
                end
            end
            i_now  = (m_t / SD) % 4;
            i_prev = (m_t == 0) ? 0 : ((m_t - 1) / SD) % 4;
            m_nib  = digit_of(prev, i_now);
            m_an   = ~(4'b0001 << i_prev);
            m_t++;
        end
    endtask

    // Called at a negedge: drive, let one rising edge pass, then compare.
    task automatic cyc(input bit r, input bit e, input bit u, input bit c,
                       input bit l, input logic [15:0] lv);
        rst_n = r; en = e; up_dn = u; clear = c; load = l; load_val = lv;
        @(posedge clk);
        model_edge(r, e, u, c, l, lv);
        @(negedge clk);
        if (m_valid) begin
            chk("count", count_bcd, to_bcd(m_cnt));
            chk("carry", {15'd0, carry}, {15'd0, m_car});
            chk("nibble", {12'd0, nibble_out}, {12'd0, m_nib});
            chk("anode", {12'd0, digit_an}, {12'd0, m_an});
        end
    endtask

    int carries;

    initial begin
        rst_n = 0; en = 1; up_dn = 1; clear = 1; load = 1; load_val = 16'h1234;
        @(negedge clk);
        // Reset with other controls active; anodes must stay dark.
        cyc(0, 1, 1, 1, 1, 16'h5555);
        cyc(0, 1, 1, 0, 1, 16'h5555);
        chk("reset_an", {12'd0, digit_an}, 16'h000F);
        chk("reset_cnt", count_bcd, 16'h0000);
        for (int i = 0; i < 8; i++) cyc(1, 1, 1, 0, 0, 16'h0);
        chk("up_8", count_bcd, 16'h0002);

        // Upward wrap
        cyc(1, 1, 1, 0, 1, 16'h9998);
        carries = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1, 1, 1, 0, 0, 16'h0);
            carries += int'(carry);
        end
        chk("up_wrap", count_bcd, 16'h0001);
        chk("up_carries", 16'(carries), 16'd1);

        // Downward wrap from clear, up_dn toggling between steps
        cyc(1, 1, 1, 1, 0, 16'h0);
        for (int i = 0; i < 8; i++) cyc(1, 1, (i % 4) != 3 ? bit'(i & 1) : 1'b0, 0, 0, 16'h0);
        chk("down_wrap", count_bcd, 16'h9998);

        // Load sanitising and clear-over-load priority
        cyc(1, 0, 1, 0, 1, 16'h1A2F);
        chk("load_clean", count_bcd, 16'h1020);
        cyc(1, 0, 1, 1, 1, 16'h7777);
        chk("clear_prio", count_bcd, 16'h0000);

        // Enable gap mid-prescale
        for (int i = 0; i < 2; i++) cyc(1, 1, 1, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 16'h0);
        cyc(1, 1, 1, 0, 0, 16'h0);
        chk("gap_hold", count_bcd, 16'h0000);
        cyc(1, 1, 1, 0, 0, 16'h0);
        chk("gap_step", count_bcd, 16'h0001);

        // Display scan of a static value
        cyc(1, 0, 1, 0, 1, 16'h4321);
        for (int i = 0; i < 16; i++) cyc(1, 0, 1, 0, 0, 16'h0);

        // Random traffic, including reset mid-step and boundary loads
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] lv;
            case ($urandom_range(0, 3))
                0: lv = 16'h9998;
                1: lv = 16'h0001;
                default: lv = 16'($urandom);
            endcase
            cyc($urandom_range(0, 79) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
                $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0, lv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clk cycles per count step (min 2).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clk cycles per display digit slot (min 2).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  synchronous reset, active-low.
REQ-005 SHALL have port en  in  1  count enable; prescaler advances only while 1.
REQ-006 SHALL have port up_dn  in  1  direction: 1 up, 0 down.
REQ-007 SHALL have port clear  in  1  synchronous clear of count.
REQ-008 SHALL have port load  in  1  synchronous load of load_val.
REQ-009 SHALL have port load_val  in  16  four BCD digits, [3:0] units … [15:12] thousands.
REQ-010 SHALL have port count_bcd  out  16  current count, same digit packing as load_val.
REQ-011 SHALL have port carry  out  1  one-cycle pulse on wrap (9999->0000 up, 0000->9999 down).
REQ-012 SHALL have port nibble_out  out  4  registered digit value for the downstream 7-segment encoder.
REQ-013 SHALL have port digit_an  out  4  active-low one-hot digit anode select.

Function
REQ-014 Priority each cycle SHALL be: rst_n=0 > clear > load > count step.
REQ-015 clear=1 SHALL set count_bcd to 0x0000 and prescaler to 0 next cycle; no carry.
REQ-016 load=1 SHALL set count_bcd to load_val next cycle, any digit >9 replaced by 0; prescaler to 0; no carry.
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 while en=1 and hold its value while en=0.
REQ-018 A step SHALL occur in the cycle prescaler equals TICK_DIV-1 with en=1; prescaler returns to 0 same edge.
REQ-019 Up step SHALL increment units; a digit at 9 becomes 0 and carries into the next digit (decimal ripple).
REQ-020 Down step SHALL decrement units; a digit at 0 becomes 9 and borrows from the next digit.
REQ-021 Wrap 9999->0000 (up) or 0000->9999 (down) SHALL assert carry for exactly the cycle after the step edge; otherwise carry=0.
REQ-022 up_dn SHALL be sampled at the step cycle only; changes between steps have no effect.
REQ-023 count_bcd SHALL never hold a digit >9.
REQ-024 Scan counter SHALL run freely 0..SCAN_DIV-1, independent of en/clear/load; digit index 0..3 advances on its wrap, 3->0.
REQ-025 nibble_out SHALL be registered from count_bcd digit[index] each cycle (1-cycle latency from count_bcd).
REQ-026 digit_an SHALL be low on bit index, delayed one further cycle relative to nibble_out, to align with the downstream encoder's 1-cycle registered output.
REQ-027 digit_an SHALL always have exactly one bit low after the first post-reset cycle.

Reset
REQ-028 On rst_n=0 at a clk edge: count_bcd=0x0000, prescaler=0, carry=0, scan counter=0, digit index=0, nibble_out=0x0, digit_an=4'b1111.
REQ-029 Reset mid-step or mid-scan SHALL discard all in-progress state; counting restarts from prescaler 0 after rst_n returns high.
REQ-030 clear/load/en asserted during reset SHALL have no effect until rst_n=1.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-031 rst_n low 2 cycles, en=1 up_dn=1 -> count_bcd 0x0001 after 4 cycles, 0x0002 after 8; digit_an 1111 during reset.
REQ-032 load_val=0x9998, load, en=1 up -> 0x9999 then 0x0000 with carry high exactly one cycle; 0x0001 next step.
REQ-033 clear then en=1 up_dn=0 -> 0x9999 after 4 cycles with carry pulse; next step 0x9998.
REQ-034 load_val=0x1A2F with load -> count_bcd 0x1020; clear and load same cycle -> 0x0000.
REQ-035 en toggled low for 3 cycles mid-prescale -> step delayed by exactly 3 cycles; count unchanged meanwhile.
REQ-036 count 0x4321, en=0 -> nibble_out cycles 1,2,3,4 every 2 cycles; digit_an 1110,1101,1011,0111 each lagging nibble_out by 1 cycle.
